div_ctrl: RTL and testbench

- Multi-cycle 32-bit integer divide sequencer for the DIV/DIVU path of the 5-stage MIPS pipeline.
- Sits beside the execute stage and produces the 64-bit {remainder, quotient} pair that flows through memory/writeback into HI/LO.
- Runs a radix-2 restoring algorithm, one quotient bit per cycle.
- Exposes a busy/ready handshake so execute can assert a pipeline stall until the result is available.

---
 rtl/div_pkg.sv | 29 ++
 rtl/div_ctrl_if.sv | 37 +++
 rtl/div_step.sv | 24 ++
 rtl/div_ctrl.sv | 132 +++++++++++++
 tb/tb_div_ctrl.sv | 177 +++++++++++++++++
 5 files changed

// File: rtl/div_pkg.sv
// Shared types and constants for the DIV/DIVU sequencer.
// Optional early exit for |dividend| < |divisor| is enabled by DIV_EARLY_EXIT_EN.
package div_pkg;

  localparam int DATA_W = 32;
  localparam int CNT_W  = 6;
  localparam int RES_W  = 2 * DATA_W;
  localparam int WORK_W = 2 * DATA_W + 1;

  typedef enum logic [1:0] {
    DIV_IDLE   = 2'd0,
    DIV_BYZERO = 2'd1,
    DIV_ON     = 2'd2,
    DIV_END    = 2'd3
  } div_state_t;

  localparam logic DIV_RESULT_READY     = 1'b1;
  localparam logic DIV_RESULT_NOT_READY = 1'b0;
  localparam logic DIV_START            = 1'b1;
  localparam logic DIV_STOP             = 1'b0;

  function automatic logic [DATA_W-1:0] mag(
    input logic [DATA_W-1:0] v,
    input logic              sg
  );
    return (sg && v[DATA_W-1]) ? -v : v;
  endfunction

endpackage

// File: rtl/div_ctrl_if.sv
// Execute-stage <-> divider handshake bundle.
// Shared by both DIV_EARLY_EXIT_EN builds.
interface div_ctrl_if;
  import div_pkg::*;

  logic              start_i;
  logic              annul_i;
  logic              signed_i;
  logic [DATA_W-1:0] opdata1_i;
  logic [DATA_W-1:0] opdata2_i;
  logic              busy_o;
  logic              ready_o;
  logic [RES_W-1:0]  result_o;

  modport master (
    output start_i,
    output annul_i,
    output signed_i,
    output opdata1_i,
    output opdata2_i,
    input  busy_o,
    input  ready_o,
    input  result_o
  );

  modport slave (
    input  start_i,
    input  annul_i,
    input  signed_i,
    input  opdata1_i,
    input  opdata2_i,
    output busy_o,
    output ready_o,
    output result_o
  );

endinterface

// File: rtl/div_step.sv
// One radix-2 restoring iteration on the {rem, quo} work register.
// Identical in both DIV_EARLY_EXIT_EN builds.
module div_step
  import div_pkg::*;
(
  input  logic [WORK_W-1:0] work_in,
  input  logic [DATA_W-1:0] divisor,
  output logic [WORK_W-1:0] work_out
);

  logic [WORK_W-1:0] sh;
  logic [DATA_W+1:0] diff;

  assign sh = {work_in[WORK_W-2:0], 1'b0};

  // Partial remainder can reach 33 bits after the shift.
  assign diff = {work_in[WORK_W-1], sh[WORK_W-1:DATA_W]}
              - {2'b00, divisor};

  assign work_out = diff[DATA_W+1]
                  ? sh
                  : {diff[DATA_W:0], sh[DATA_W-1:1], 1'b1};

endmodule

// File: rtl/div_ctrl.sv
// Multi-cycle DIV/DIVU sequencer, one quotient bit per cycle.
// Define DIV_EARLY_EXIT_EN to finish at once when |dividend| < |divisor|.
module div_ctrl
  import div_pkg::*;
(
  input logic       clk,
  input logic       rst,
  div_ctrl_if.slave bus
);

  div_state_t        state;
  logic [CNT_W-1:0]  cnt;
  logic [WORK_W-1:0] work;
  logic [WORK_W-1:0] work_nx;
  logic [DATA_W-1:0] dvsr;
  logic              neg_a;
  logic              neg_b;
  logic              sgn;
  logic              busy;
  logic              ready;
  logic [RES_W-1:0]  result;

  logic [DATA_W-1:0] abs_a;
  logic [DATA_W-1:0] abs_b;
  logic [DATA_W-1:0] quo;
  logic [DATA_W-1:0] rem;
  logic              go;
  logic              last;
  logic              early;

  assign abs_a = mag(bus.opdata1_i, bus.signed_i);
  assign abs_b = mag(bus.opdata2_i, bus.signed_i);
  assign go    = (bus.start_i == DIV_START) && !bus.annul_i;
  assign last  = (cnt == CNT_W'(DATA_W - 1));

`ifdef DIV_EARLY_EXIT_EN
  assign early = (abs_a < abs_b);
`else
  assign early = 1'b0;
`endif

  div_step u_step (
    .work_in  (work),
    .divisor  (dvsr),
    .work_out (work_nx)
  );

  // Sign fix on the final iteration's output.
  assign quo = (sgn && (neg_a ^ neg_b))
             ? -work_nx[DATA_W-1:0]
             : work_nx[DATA_W-1:0];
  assign rem = (sgn && neg_a)
             ? -work_nx[2*DATA_W-1:DATA_W]
             : work_nx[2*DATA_W-1:DATA_W];

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= DIV_IDLE;
      cnt    <= '0;
      work   <= '0;
      dvsr   <= '0;
      neg_a  <= 1'b0;
      neg_b  <= 1'b0;
      sgn    <= 1'b0;
      busy   <= 1'b0;
      ready  <= DIV_RESULT_NOT_READY;
      result <= '0;
    end else begin
      unique case (state)
        DIV_IDLE: begin
          if (go) begin
            if (bus.opdata2_i == '0) begin
              state <= DIV_BYZERO;
              busy  <= 1'b1;
            end else if (early) begin
              state  <= DIV_END;
              result <= {bus.opdata1_i, {DATA_W{1'b0}}};
            end else begin
              state <= DIV_ON;
              busy  <= 1'b1;
              cnt   <= '0;
              dvsr  <= abs_b;
              work  <= {{(DATA_W+1){1'b0}}, abs_a};
              sgn   <= bus.signed_i;
              neg_a <= bus.opdata1_i[DATA_W-1];
              neg_b <= bus.opdata2_i[DATA_W-1];
            end
          end
        end
        DIV_BYZERO: begin
          state  <= DIV_END;
          busy   <= 1'b0;
          result <= '0;
        end
        DIV_ON: begin
          if (bus.annul_i) begin
            state <= DIV_IDLE;
            busy  <= 1'b0;
          end else begin
            work <= work_nx;
            cnt  <= cnt + CNT_W'(1);
            if (last) begin
              state  <= DIV_END;
              busy   <= 1'b0;
              result <= {rem, quo};
            end
          end
        end
        DIV_END: begin
          // Result lands one edge before ready so it is stable when seen.
          if (bus.start_i == DIV_STOP) begin
            state  <= DIV_IDLE;
            ready  <= DIV_RESULT_NOT_READY;
            result <= '0;
          end else begin
            ready <= DIV_RESULT_READY;
          end
        end
        default: begin
          state <= DIV_IDLE;
          busy  <= 1'b0;
          ready <= DIV_RESULT_NOT_READY;
        end
      endcase
    end
  end

  assign bus.busy_o   = busy;
  assign bus.ready_o  = ready;
  assign bus.result_o = result;

endmodule

// File: tb/tb_div_ctrl.sv
// Directed bench for div_ctrl with an arithmetic reference model.
// Also builds with DIV_EARLY_EXIT_EN defined.
module tb_div_ctrl;
  import div_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  div_ctrl_if bus ();

  div_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  logic        chk_en = 1'b0;
  logic        active = 1'b0;
  int          t0     = 0;
  int          lat    = 0;
  int          blen   = 0;
  logic [63:0] exp_res = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %h want %h", nm, cyc, act, want);
    end
  endtask

  // Reference: plain 64-bit arithmetic, timing from operand class.
  task automatic model(input logic sg, input logic [31:0] a,
                       input logic [31:0] b, output logic [63:0] res,
                       output int lt, output int bl);
    longint x, y, q, r;
    x = sg ? longint'($signed(a)) : longint'({32'b0, a});
    y = sg ? longint'($signed(b)) : longint'({32'b0, b});
    if (y == 0) begin
      res = '0;
      lt  = 2;
      bl  = 1;
    end else begin
      q   = x / y;
      r   = x % y;
      res = {r[31:0], q[31:0]};
      lt  = 33;
      bl  = 32;
`ifdef DIV_EARLY_EXIT_EN
      if ((x < 0 ? -x : x) < (y < 0 ? -y : y)) begin
        lt = 1;
        bl = 0;
      end
`endif
    end
  endtask

  always @(negedge clk) begin
    logic e_rdy, e_busy;
    if (chk_en) begin
      e_rdy  = active && (cyc >= t0 + lat);
      e_busy = active && (cyc >= t0) && (cyc < t0 + blen);
      chk("ready", 64'(bus.ready_o), 64'(e_rdy));
      chk("busy", 64'(bus.busy_o), 64'(e_busy));
      if (!active || e_rdy)
        chk("result", bus.result_o, active ? exp_res : 64'd0);
    end
  end

  task automatic launch(input logic sg, input logic [31:0] a,
                        input logic [31:0] b);
    @(posedge clk); #1;
    bus.start_i   = 1'b1;
    bus.signed_i  = sg;
    bus.opdata1_i = a;
    bus.opdata2_i = b;
    t0 = cyc + 1;
    model(sg, a, b, exp_res, lat, blen);
    active = 1'b1;
  endtask

  task automatic run_op(input string nm, input logic sg,
                        input logic [31:0] a, input logic [31:0] b,
                        input int lat_lit, input logic [63:0] lit);
    launch(sg, a, b);
    chk({nm, "_model"}, exp_res, lit);
    chk({nm, "_lat"}, 64'(lat), 64'(lat_lit));
    repeat (lat_lit + 1) @(negedge clk);
    chk({nm, "_notyet"}, 64'(bus.ready_o), 64'd0);
    @(negedge clk);
    chk({nm, "_ready"}, 64'(bus.ready_o), 64'd1);
    chk({nm, "_res"}, bus.result_o, lit);
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    @(posedge clk); #1;
    active = 1'b0;
    @(negedge clk);
    chk({nm, "_drop"}, 64'(bus.ready_o), 64'd0);
  endtask

  // Kill an op in its k-th ON cycle by annul (use_rst=0) or reset.
  task automatic run_abort(input string nm, input logic use_rst,
                           input logic sg, input logic [31:0] a,
                           input logic [31:0] b, input int k);
    launch(sg, a, b);
    repeat (k) @(posedge clk);
    #1;
    bus.start_i = 1'b0;
    if (use_rst) rst = 1'b1;
    else bus.annul_i = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    bus.annul_i = 1'b0;
    active = 1'b0;
    @(negedge clk);
    chk({nm, "_busy"}, 64'(bus.busy_o), 64'd0);
    chk({nm, "_idle"}, {bus.result_o[62:0], bus.ready_o}, 64'd0);
    repeat (40) @(posedge clk);
  endtask

  initial begin
    bus.start_i   = 1'b0;
    bus.annul_i   = 1'b0;
    bus.signed_i  = 1'b0;
    bus.opdata1_i = '0;
    bus.opdata2_i = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 64'(bus.ready_o), 64'd0);
    chk("rst_busy", 64'(bus.busy_o), 64'd0);
    chk("rst_result", bus.result_o, 64'd0);
    chk_en = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;

    run_op("divu_100_7", 1'b0, 32'd100, 32'd7, 33,
           {32'd2, 32'd14});
    run_op("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 33,
           {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    run_op("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 33,
           {32'h0000_0001, 32'hFFFF_FFFD});
    run_op("div_5_0", 1'b1, 32'd5, 32'd0, 2, 64'd0);
    run_abort("annul", 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd3, 10);
    run_op("divu_max_3", 1'b0, 32'hFFFF_FFFF, 32'd3, 33,
           {32'd0, 32'h5555_5555});
    run_op("div_min_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 33,
           {32'd0, 32'h8000_0000});
`ifdef DIV_EARLY_EXIT_EN
    run_op("divu_3_10", 1'b0, 32'd3, 32'd10, 1, {32'd3, 32'd0});
    run_op("divu_0_5", 1'b0, 32'd0, 32'd5, 1, 64'd0);
`else
    run_op("divu_3_10", 1'b0, 32'd3, 32'd10, 33, {32'd3, 32'd0});
    run_op("divu_0_5", 1'b0, 32'd0, 32'd5, 33, 64'd0);
`endif
    run_abort("midrst", 1'b1, 1'b1, 32'd1000, 32'hFFFF_FFFD, 20);
    run_op("div_1000_m3", 1'b1, 32'd1000, 32'hFFFF_FFFD, 33,
           {32'h0000_0001, 32'hFFFF_FEB3});
    run_op("divu_wide", 1'b0, 32'hFFFF_FFFF, 32'h8000_0001, 33,
           {32'h7FFF_FFFE, 32'd1});
    run_op("div_m100_m7", 1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 33,
           {32'hFFFF_FFFE, 32'd14});

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
